// File: rtl/poly_mem_arbiter_if.sv
// Requester-side bus of the coefficient RAM arbiter: three packed request lanes in, grants and read data out.
// No latency of its own; it only carries signals.
// Flow control: req is held until gnt arrives, and rvalid qualifies rdata.
interface poly_mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 13
);
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;

  // requester side
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  // arbiter side
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/poly_mem_arbiter.sv
// Round-robin arbiter sharing one single-port coefficient RAM among clear engine (0), subtractor (1) and divider (2).
// Latency: a grant arrives 1 cycle after the request; read data returns 1 cycle after the access.
// Flow control: non-owners wait while req is held; a burst ends on req drop or on the hold watchdog.
module poly_mem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 13,
  parameter int DEPTH    = 677,
  parameter int MAX_HOLD = 1024
) (
  input  logic                clk,
  input  logic                rst,
  poly_mem_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_addr,
  output logic                err_timeout,
  output logic                busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  // One extra bit so that DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          gnt_q, gnt_nxt;
  logic [1:0]          rr_ptr, rr_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                timeout_fire;
  logic [2:0]          rvalid_q;
  logic                rd_oor_q;

  logic [1:0]          owner;
  logic [1:0]          pick;
  logic                sel_req, sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                access, in_range;

  // Decode the owner index and select its request lane; also find the next winner from the RR pointer
  always_comb begin
    owner     = 2'd0;
    sel_req   = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    pick      = 2'd0;
    if (gnt_q[1])      owner = 2'd1;
    else if (gnt_q[2]) owner = 2'd2;
    case (owner)
      2'd1: begin
        sel_req   = bus.req[1];
        sel_we    = bus.we[1];
        sel_addr  = bus.addr[1*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[1*DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_req   = bus.req[2];
        sel_we    = bus.we[2];
        sel_addr  = bus.addr[2*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        sel_req   = bus.req[0];
        sel_we    = bus.we[0];
        sel_addr  = bus.addr[0 +: ADDR_W];
        sel_wdata = bus.wdata[0 +: DATA_W];
      end
    endcase
    case (rr_ptr)
      2'd0:    pick = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
      2'd1:    pick = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      default: pick = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
    endcase
  end

  // State register: FSM state plus the grant, round-robin pointer and hold counter it owns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      rr_ptr   <= 2'd0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt_q    <= gnt_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next state: grant on request, release on req drop or watchdog expiry, then one idle turnaround cycle
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt_q;
    rr_nxt       = rr_ptr;
    hold_nxt     = hold_cnt;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = OWN;
          gnt_nxt   = 3'b001 << pick;
          hold_nxt  = '0;
        end
      end
      OWN: begin
        if (!sel_req || hold_cnt == HOLD_LAST) begin
          // A req drop coinciding with expiry is an ordinary release
          timeout_fire = sel_req;
          state_nxt    = RELEASE;
          gnt_nxt      = '0;
          rr_nxt       = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
          hold_nxt     = '0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: steer the owner onto the RAM port; writes beyond DEPTH are dropped
  always_comb begin
    access    = sel_req & (|gnt_q);
    in_range  = {1'b0, sel_addr} < DEPTH_L;
    mem_addr  = access ? sel_addr : '0;
    mem_wdata = access ? sel_wdata : '0;
    mem_we    = access & sel_we & in_range;
    bus.gnt    = gnt_q;
    bus.rvalid = rvalid_q;
    bus.rdata  = ((|rvalid_q) && !rd_oor_q) ? mem_rdata : '0;
    busy       = |gnt_q;
  end

  // Read-return tracking and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q    <= '0;
      rd_oor_q    <= 1'b0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rvalid_q    <= (access && !sel_we) ? gnt_q : 3'b000;
      rd_oor_q    <= access & ~sel_we & ~in_range;
      err_addr    <= err_addr | (access & ~in_range);
      err_timeout <= err_timeout | timeout_fire;
    end
  end

endmodule

// File: tb/tb_poly_mem_arbiter.sv
// Directed bench for poly_mem_arbiter with a behavioural 1-cycle RAM and MAX_HOLD reduced to 8.
module tb_poly_mem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 13;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_addr, err_timeout, busy;

  poly_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  poly_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(677), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .err_addr(err_addr), .err_timeout(err_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: every word preloaded with i*7+100, one-cycle read latency
  logic [DATA_W-1:0] ram [0:2047];
  logic ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 2048; i++) ram[i] <= DATA_W'(i * 7 + 100);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int owners [8];
  int gaps   [8];
  int n_own;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int n, input logic r, input logic w, input int a, input int d);
    bus.req[n] = r;
    bus.we[n]  = w;
    bus.addr[n*ADDR_W +: ADDR_W]  = ADDR_W'(a);
    bus.wdata[n*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic wait_gnt(input int n, input string tag);
    for (int c = 0; c < 20 && !bus.gnt[n]; c++) step();
    check(tag, 32'(bus.gnt[n]), 32'd1);
  endtask

  function automatic int owner_of(input logic [2:0] g);
    return g[1] ? 1 : (g[2] ? 2 : 0);
  endfunction

  // Records successive owners and the no-grant gap before each; requesters drop req
  // on their burst-th granted cycle and re-raise when ungranted if flagged in rereq.
  task automatic track(input int want, input int burst, input logic [2:0] rereq);
    int cnt [3];
    int zeros;
    logic [2:0] prev;
    cnt   = '{0, 0, 0};
    zeros = 0;
    n_own = 0;
    prev  = bus.gnt;
    for (int c = 0; c < 80 && n_own < want; c++) begin
      step();
      if (bus.gnt == 3'b000) zeros++;
      else if (prev == 3'b000) begin
        owners[n_own] = owner_of(bus.gnt);
        gaps[n_own]   = zeros;
        zeros = 0;
        n_own++;
      end
      for (int n = 0; n < 3; n++) begin
        if (bus.gnt[n]) begin
          cnt[n]++;
          if (cnt[n] == burst) begin
            bus.req[n] = 1'b0;
            cnt[n] = 0;
          end
        end else if (rereq[n]) begin
          bus.req[n] = 1'b1;
        end
      end
      prev = bus.gnt;
    end
    check("track_owners_seen", 32'(n_own), 32'(want));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "bench did not complete");
  end

  initial begin
    int hc;
    logic et_before;
    do_reset();

    // Reset state
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);

    // Single grant to requester 1 with a write to address 5
    rst = 1'b0;
    drive(1, 1'b1, 1'b0, 0, 0);
    step();
    check("t1_gnt", 32'(bus.gnt), 32'b010);
    check("t1_busy", 32'(busy), 32'd1);
    drive(1, 1'b1, 1'b1, 5, 'h1ABC);
    #1;
    check("t1_mem_we", 32'(mem_we), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'd5);
    check("t1_mem_wdata", 32'(mem_wdata), 32'h1ABC);
    step();
    drive(1, 1'b0, 1'b0, 5, 0);
    #1;
    check("t1_idle_mem_we", 32'(mem_we), 32'd0);
    check("t1_idle_mem_addr", 32'(mem_addr), 32'd0);
    step();
    check("t1_release_gnt", 32'(bus.gnt), 32'd0);
    step();
    check("t1_idle_gnt", 32'(bus.gnt), 32'd0);
    check("t1_ram5", 32'(ram[5]), 32'h1ABC);

    // Round robin with all three requesting, 4-cycle bursts
    do_reset();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) drive(n, 1'b1, 1'b0, n, 0);
    track(4, 4, 3'b111);
    check("rr_owner0", 32'(owners[0]), 32'd0);
    check("rr_owner1", 32'(owners[1]), 32'd1);
    check("rr_owner2", 32'(owners[2]), 32'd2);
    check("rr_owner3", 32'(owners[3]), 32'd0);
    check("rr_gap1", 32'(gaps[1]), 32'd2);
    check("rr_gap2", 32'(gaps[2]), 32'd2);
    check("rr_gap3", 32'(gaps[3]), 32'd2);

    // Owner 2 reads addresses 0..3 back to back
    do_reset();
    rst = 1'b0;
    drive(2, 1'b1, 1'b0, 0, 0);
    wait_gnt(2, "rd_gnt2");
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) drive(2, 1'b1, 1'b0, i + 1, 0);
      else       drive(2, 1'b0, 1'b0, 0, 0);
      #1;
      check($sformatf("rd_rvalid_%0d", i), 32'(bus.rvalid), 32'b100);
      check($sformatf("rd_rdata_%0d", i), 32'(bus.rdata), 32'(i * 7 + 100));
    end
    step();
    check("rd_rvalid_end", 32'(bus.rvalid), 32'd0);
    check("rd_rdata_end", 32'(bus.rdata), 32'd0);

    // Out-of-range write and read by owner 0
    drive(0, 1'b1, 1'b1, 677, 'h55);
    wait_gnt(0, "oor_gnt0");
    #1;
    check("oor_mem_we", 32'(mem_we), 32'd0);
    check("oor_mem_addr", 32'(mem_addr), 32'd677);
    step();
    check("oor_err_addr", 32'(err_addr), 32'd1);
    drive(0, 1'b1, 1'b0, 700, 0);
    step();
    drive(0, 1'b0, 1'b0, 0, 0);
    #1;
    check("oor_rvalid", 32'(bus.rvalid), 32'b001);
    check("oor_rdata", 32'(bus.rdata), 32'd0);
    step();
    check("oor_err_sticky", 32'(err_addr), 32'd1);
    check("oor_ram677", 32'(ram[677]), 32'(677 * 7 + 100));

    // Watchdog: owner 1 holds req, others wait
    drive(1, 1'b1, 1'b0, 1, 0);
    wait_gnt(1, "wd_gnt1");
    drive(0, 1'b1, 1'b0, 2, 0);
    drive(2, 1'b1, 1'b0, 3, 0);
    hc = 1;
    et_before = err_timeout;
    for (int c = 0; c < 30; c++) begin
      step();
      if (!bus.gnt[1]) break;
      hc++;
      et_before = err_timeout;
    end
    check("wd_hold_cycles", 32'(hc), 32'd8);
    check("wd_err_before", 32'(et_before), 32'd0);
    check("wd_err_timeout", 32'(err_timeout), 32'd1);
    check("wd_gnt_dropped", 32'(bus.gnt), 32'd0);
    track(3, 2, 3'b010);
    check("wd_next0", 32'(owners[0]), 32'd2);
    check("wd_next1", 32'(owners[1]), 32'd0);
    check("wd_next2", 32'(owners[2]), 32'd1);

    // Reset in the middle of owner 1's write burst
    drive(1, 1'b1, 1'b1, 10, 'hAA);
    #1;
    check("mr_mem_we_before", 32'(mem_we), 32'd1);
    check("mr_err_timeout_before", 32'(err_timeout), 32'd1);
    rst = 1'b1;
    #1;
    check("mr_gnt", 32'(bus.gnt), 32'd0);
    check("mr_rvalid", 32'(bus.rvalid), 32'd0);
    check("mr_mem_we", 32'(mem_we), 32'd0);
    check("mr_err_addr", 32'(err_addr), 32'd0);
    check("mr_err_timeout", 32'(err_timeout), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    drive(0, 1'b1, 1'b0, 0, 0);
    drive(1, 1'b1, 1'b0, 0, 0);
    drive(2, 1'b0, 1'b0, 0, 0);
    step();
    rst = 1'b0;
    step();
    check("mr_first_gnt", 32'(bus.gnt), 32'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_mem_arbiter.md
Name: poly_mem_arbiter

Overview:
- Shares one single-port polynomial coefficient RAM (677 x 13-bit, 1-cycle read latency) among three requesters inside the polynomial-division subsystem: requester 0 = clear/reset engine, 1 = subtractor, 2 = division datapath.
- Replaces the hand-built select-line muxing of RAM address/data/write-enable with a request/grant arbiter.
- Arbitration is round-robin. A grant is held for a burst. An address range check and a hold watchdog protect the RAM.

Parameters:
- ADDR_W, 11, RAM address width.
- DATA_W, 13, coefficient width.
- DEPTH, 677, number of valid RAM words. Legal addresses are 0..DEPTH-1.
- MAX_HOLD, 1024, maximum consecutive cycles one requester may hold the grant.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  3  per-requester bus request. Bit n belongs to requester n.
- we  in  3  per-requester write strobe. Qualified by req[n] and gnt[n].
- addr  in  3*ADDR_W  per-requester address. Requester n uses bits [n*ADDR_W +: ADDR_W].
- wdata  in  3*DATA_W  per-requester write data, packed the same way as addr.
- gnt  out  3  one-hot grant, registered.
- rvalid  out  3  one-hot read-data-valid pulse.
- rdata  out  DATA_W  read data, common to all requesters. Qualified by rvalid.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address.
- err_addr  out  1  sticky out-of-range flag.
- err_timeout  out  1  sticky watchdog flag.
- busy  out  1  high whenever any grant is active.

Behaviour:
- Reset (asynchronous, rst=1):
  - gnt=0, rvalid=0, err_addr=0, err_timeout=0, busy=0.
  - Round-robin pointer set to requester 0 (highest priority is 0).
  - Hold counter = 0. State = IDLE.
- States:
  - IDLE: no grant.
  - OWN: exactly one gnt bit high.
  - RELEASE: one-cycle bus turnaround with no grant.
- IDLE transitions:
  - If req≠0, pick the first requester with req high, searching upward from the RR pointer with wrap-around 2->0.
  - Next cycle: that gnt bit = 1, state = OWN, hold counter = 0.
  - Grant latency from request is 1 cycle.
- OWN behaviour:
  - Each cycle with req[owner]=1 is one access: a write if we[owner]=1, otherwise a read.
  - Hold counter increments by 1 per cycle.
- OWN exit (either condition):
  - req[owner] deasserts, or hold counter reaches MAX_HOLD-1 with req still high.
  - Next cycle: gnt=0, state = RELEASE, RR pointer = owner+1 mod 3.
- Watchdog case: the forced release also sets err_timeout. The requester must re-request to continue.
- RELEASE: always goes to IDLE next cycle. The minimum gap between two different owners is 2 cycles with no grant.
- RAM port (combinational from the owner):
  - When gnt[n]=1 and req[n]=1: mem_addr = addr[n], mem_wdata = wdata[n], mem_we = we[n] AND (addr[n] < DEPTH).
  - Otherwise: mem_addr=0, mem_wdata=0, mem_we=0.
- Range check:
  - Any granted access with addr ≥ DEPTH sets err_addr, which stays high until reset.
  - An out-of-range write is suppressed.
  - An out-of-range read still returns an rvalid pulse with rdata=0.
- Read data:
  - A granted read in cycle t gives rvalid[n]=1 in cycle t+1, with rdata = mem_rdata (0 if out of range).
  - rvalid is registered and tracks the requester that issued the read, even if its grant dropped in cycle t+1.
  - rdata = 0 when rvalid=0.
- Simultaneous events:
  - req deasserting in the same cycle the watchdog fires counts as a normal release; err_timeout is not set.
  - Requests that arrive while in OWN or RELEASE wait; they are never lost as long as req stays high.
- A requester that deasserts req while not granted is simply skipped; there is no queueing.
- A reset mid-burst aborts at once: outputs return to reset values, and a write in flight in that cycle is not guaranteed.
- busy = |gnt.

Test Plan:
- Reset release with req=3'b010 at t0 -> gnt=3'b010 at t1. Write addr=5, wdata=0x1ABC -> mem_we=1, mem_addr=5. Drop req -> gnt=0 next cycle, RELEASE for 1 cycle.
- req=3'b111 held continuously with bursts of 4 cycles each -> grant order 0,1,2,0. Each change of owner is separated by 2 no-grant cycles. No requester starves.
- Owner 2 reads addr 0..3 back-to-back -> rvalid[2] on 4 consecutive cycles, 1 cycle after each read, with rdata equal to the RAM contents. The last rvalid arrives after req drops.
- Owner 0 writes addr=677 -> mem_we stays 0 and err_addr rises and stays high. A read of addr=700 -> rvalid with rdata=0.
- MAX_HOLD=8, owner 1 holds req for 20 cycles -> gnt[1] drops after exactly 8 granted cycles and err_timeout=1. Owner 1 is re-granted only after the other requesters are served.
- Assert rst mid-burst (owner 1, write in progress) -> gnt, rvalid, mem_we and both error flags go to 0 immediately. After rst drops with req=3'b011 -> requester 0 is granted first.
